pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
Two-entry valid/ready pipeline stage with a skid buffer. It is the consumer-facing counterpart of the plain enable register. Instead of taking a downstream enable, it generates its own upstream back-pressure (in_ready) from the downstream ready. It sits between pipeline stages so a stall from a later stage need not combinationally reach earlier stages. It supports a synchronous flush for branch/hazard kills.

Parameters:
WIDTH, 8, data path width in bits

Ports:
CLK  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  upstream presents in_data this cycle
in_ready  output  1  stage can accept a word this cycle; registered
in_data  input  WIDTH  upstream data
out_valid  output  1  out_data holds a valid word
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  head-of-stage data; driven from the main register
occupancy  output  2  number of held words, 0..2

Behaviour:
- Storage: main register (main_q, main_v) and skid register (skid_q, skid_v). out_data = main_q; out_valid = main_v.
- Handshakes:
  - Upstream transfer (push) occurs when in_valid & in_ready.
  - Downstream transfer (pop) occurs when out_valid & out_ready.
- in_ready = ~skid_v. It is registered: it depends only on state, never on out_ready in the same cycle.
- States, encoded by occupancy:
  - EMPTY (0): main_v=0, skid_v=0.
  - ONE (1): main_v=1, skid_v=0.
  - TWO (2): main_v=1, skid_v=1.
- EMPTY transitions:
  - push → ONE, main_q <= in_data.
  - no push → stay EMPTY.
- ONE transitions:
  - push & pop → ONE, main_q <= in_data.
  - push & ~pop → TWO, skid_q <= in_data.
  - ~push & pop → EMPTY.
  - neither → hold.
- TWO transitions:
  - push is impossible because in_ready=0.
  - pop → ONE, main_q <= skid_q.
  - no pop → hold both registers.
- Latency: a word pushed in cycle N appears on out_data/out_valid in cycle N+1 when the stage was EMPTY, or ONE with a pop. No combinational path from in_* to out_*.
- Order: strict FIFO order. A word never bypasses an older held word.
- Words presented while in_ready=0 are not captured. Upstream must hold in_valid/in_data until accepted.
- flush:
  - On the next edge, main_v <= 0, skid_v <= 0, occupancy <= 0, in_ready <= 1.
  - A push or pop in the flush cycle is discarded. Upstream must consider any in-flight push lost.
- Priority: reset > flush > normal operation.
- Reset values:
  - main_v=0, skid_v=0, out_valid=0, in_ready=1, occupancy=0.
  - main_q and skid_q are 0, so out_data=0.
- Reset mid-operation discards all held data identically to flush, including in TWO.
- While valid is low, data registers keep their previous contents. Only the *_v bits are cleared by flush. Reset clears the data registers as well.
- No X propagation: out_data is always a defined register value.

Test Plan:
- Reset, then in_valid=1, in_data=0x11, out_ready=1 for 1 cycle → next cycle out_valid=1, out_data=0x11, occupancy=1, in_ready=1. After reset, out_data=0 and in_ready=1.
- Streaming: push 0x01..0x08 on consecutive cycles with out_ready=1 → out_data sequence 0x01..0x08 one cycle delayed, occupancy stays 1, in_ready never drops.
- Stall/skid:
  - Push 0xA0, then 0xA1 with out_ready=0 → occupancy=2, in_ready=0, out_data=0xA0. 0xA2 held on input is not captured.
  - Raise out_ready → pops give 0xA0 then 0xA1, then 0xA2 is accepted. No loss or duplication.
- Random in_valid/out_ready patterns for 1000 cycles with a scoreboard → output order equals input order, and occupancy equals scoreboard depth every cycle.
- Flush in TWO, with simultaneous in_valid=1 and out_ready=1 → next cycle out_valid=0, occupancy=0, in_ready=1. The pushed word and both held words are not seen on the output.
- Assert reset in state TWO concurrently with flush=0 and a pending push → next cycle all valids 0, out_data=0, in_ready=1. Subsequent push 0x5A emerges normally.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline stage with a skid register so downstream
// stalls never reach upstream combinationally; in_ready is a flop.
module pipe_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_q;
    logic [WIDTH-1:0] r_skid_q;
    logic             r_in_ready;
    logic [1:0]       r_occ;
    logic [1:0]       w_occ_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_ld_main_in;
    logic             w_ld_main_skid;
    logic             w_ld_skid;

    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main_q;
    assign in_ready  = r_in_ready;
    assign occupancy = r_occ;

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt  = ST_ONE;
                    w_ld_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_ld_main_in = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = ST_TWO;
                    w_ld_skid   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can move the state
                if (w_pop) begin
                    w_state_nxt    = ST_ONE;
                    w_ld_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // A flush kills everything held and any push/pop in the same cycle
        if (flush) begin
            w_state_nxt    = ST_EMPTY;
            w_ld_main_in   = 1'b0;
            w_ld_main_skid = 1'b0;
            w_ld_skid      = 1'b0;
        end
    end

    always_comb begin
        w_occ_nxt = 2'd0;
        case (w_state_nxt)
            ST_ONE:  w_occ_nxt = 2'd1;
            ST_TWO:  w_occ_nxt = 2'd2;
            default: w_occ_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_occ      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            r_occ      <= w_occ_nxt;
        end
    end

    // Data registers hold their contents when idle or flushed; only reset clears them
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_main_q <= '0;
            r_skid_q <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_q <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_q <= r_skid_q;
            end
            if (w_ld_skid) begin
                r_skid_q <= in_data;
            end
        end
    end

endmodule
